enc4x2_reg: RTL and testbench
=============================

// Module: enc4x2_reg
// PURPOSE
//  Registered 4-to-2 priority encoder with valid/ack handshake. Inverse of the 2-to-4 decoder.
//  Samples 4 request lines D[3:0] while enabled and captures the index of the highest set bit.
//  Holds {A,V} stable until the consumer acks, then re-arms.
//  Sits between request/one-hot sources (e.g. decoder outputs, buttons) and a code consumer.
// PARAMETERS
//  AW              2   code width; request width N = 2**AW (default 4 lines)
//  REARM_ON_RELEASE 1  1: after ack wait for D==0 before next capture; 0: re-arm immediately
// PORTS
//  clk    in   1    rising-edge clock, one clock domain
//  rst    in   1    asynchronous, active-high reset
//  E      in   1    active-high enable; gates new captures only
//  D      in   N    request lines, D[k] <-> code k; D[N-1] highest priority
//  ack    in   1    consumer accepts held code (sampled at clk edge)
//  A      out  AW   captured code, registered
//  V      out  1    code valid, registered
//  MULTI  out  1    captured D had >1 bit set (not one-hot), registered
// BEHAVIOUR
//  Reset: state=IDLE, A=0, V=0, MULTI=0. Async assert; reset mid-HOLD drops V at once, code lost.
//  FSM, 3 states:
//   IDLE: V=0. If E=1 && D!=0 at edge -> A<=prio(D), MULTI<=(popcount(D)>1), V<=1, go HOLD.
//         If E=0 or D=0 -> stay. ack ignored.
//   HOLD: V=1; A and MULTI frozen; D and E ignored (E=0 does not abort a held code).
//         ack=1 -> V<=0; go RELEASE if REARM_ON_RELEASE else IDLE.
//   RELEASE: V=0. D==0 at edge -> IDLE. E and ack ignored.
//  Latency: request to V=1 is 1 edge. Ack to V=0 is 1 edge. With REARM=0, earliest re-capture is the 2nd edge after ack.
//  Simultaneous ack and a new request in HOLD: ack consumed; new request not captured that edge.
//  Once V=0, A and MULTI keep the last captured values until the next capture.
//  prio(D): index of highest set bit; D=0 never captured.
//  D is treated as synchronous to clk; no synchronizer inside.
// STRUCTURE
//  Shared package/header enc_pkg: state encodings IDLE=2'b00, HOLD=2'b01, RELEASE=2'b10;
//  a default AW=2 constant.
//  Sub-module prio_enc4x2 (combinational): D[N-1:0] -> {code[AW-1:0], any, multi}.
//  Top holds the FSM and the A/V/MULTI registers. Unused state 2'b11 -> IDLE.
// TESTING
//  1 rst pulse mid-HOLD (A=10,V=1) -> A=00, V=0, MULTI=0 immediately, state IDLE after release.
//  2 E=1, D=0100 -> next edge A=10, V=1, MULTI=0. Hold D=0001 with no ack -> A stays 10.
//  3 E=1, D=1011 -> A=11, MULTI=1. ack 1 cycle -> V=0. D!=0 -> no capture (RELEASE).
//    D=0000 then D=0010 -> A=01, V=1.
//  4 E=0, sweep D=0001..1111 -> V stays 0. E=1 in HOLD then E=0 -> V stays 1 until ack.
//  5 Loopback: decoder(E=1, A=k) -> D -> this block, k=0..3 -> A=k, MULTI=0, ack between vectors.
//  6 REARM_ON_RELEASE=0 with D=1000 held, ack every HOLD cycle -> V toggles 1,0,1,0; A=11 throughout.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the registered priority encoder: FSM state codes and default code width.
package enc_pkg;

    localparam int AW_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        RELEASE = 2'b10
    } state_t;

endpackage

// File: rtl/prio_enc4x2.sv
// Combinational priority encoder: index of the highest set request bit, plus any/multi flags.
module prio_enc4x2 #(
    parameter int AW = 2
) (
    input  logic [2**AW-1:0] d_i,
    output logic [AW-1:0]    code_o,
    output logic             any_o,
    output logic             multi_o
);

    localparam int N = 2**AW;

    // Ascending scan so the last hit, i.e. the highest set bit, wins.
    always_comb begin
        code_o = '0;
        for (int i = 0; i < N; i++) begin
            if (d_i[i]) begin
                code_o = i[AW-1:0];
            end
        end
    end

    assign any_o   = |d_i;
    // Clearing the lowest set bit leaves something only when more than one bit was set.
    assign multi_o = |(d_i & (d_i - N'(1)));

endmodule

// File: rtl/enc4x2_reg.sv
// Registered priority encoder with valid/ack handshake: captures prio(D) and holds it until acked.
module enc4x2_reg
    import enc_pkg::*;
#(
    parameter int AW               = AW_DEFAULT,
    parameter bit REARM_ON_RELEASE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic [2**AW-1:0] D,
    input  logic             ack,
    output logic [AW-1:0]    A,
    output logic             V,
    output logic             MULTI
);

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic          v_q, v_d;
    logic          multi_q, multi_d;

    logic [AW-1:0] enc_code;
    logic          enc_any;
    logic          enc_multi;

    prio_enc4x2 #(.AW(AW)) u_prio (
        .d_i     (D),
        .code_o  (enc_code),
        .any_o   (enc_any),
        .multi_o (enc_multi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            v_q     <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            v_q     <= v_d;
            multi_q <= multi_d;
        end
    end

    // A and MULTI only move on a capture; they keep the last code after V drops.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        v_d     = v_q;
        multi_d = multi_q;
        case (state_q)
            IDLE: begin
                v_d = 1'b0;
                if (E && enc_any) begin
                    a_d     = enc_code;
                    multi_d = enc_multi;
                    v_d     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                v_d = 1'b1;
                if (ack) begin
                    v_d     = 1'b0;
                    state_d = REARM_ON_RELEASE ? RELEASE : IDLE;
                end
            end
            RELEASE: begin
                v_d = 1'b0;
                if (!enc_any) begin
                    state_d = IDLE;
                end
            end
            default: begin
                v_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign A     = a_q;
    assign V     = v_q;
    assign MULTI = multi_q;

endmodule

// File: tb/tb_enc4x2_reg.sv
// Bench for enc4x2_reg: behavioural model compared every cycle plus directed literal checks.
module tb_enc4x2_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       e     [2];
    logic [3:0] d     [2];
    logic       ack   [2];
    logic [1:0] a_o   [2];
    logic       v_o   [2];
    logic       mul_o [2];

    logic       m_v   [2];
    logic [1:0] m_a   [2];
    logic       m_mul [2];
    logic       m_rel [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0 waits for release after ack; instance 1 re-arms immediately.
    enc4x2_reg #(.AW(2), .REARM_ON_RELEASE(1'b1)) dut (
        .clk(clk), .rst(rst), .E(e[0]), .D(d[0]), .ack(ack[0]),
        .A(a_o[0]), .V(v_o[0]), .MULTI(mul_o[0])
    );

    enc4x2_reg #(.AW(2), .REARM_ON_RELEASE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .E(e[1]), .D(d[1]), .ack(ack[1]),
        .A(a_o[1]), .V(v_o[1]), .MULTI(mul_o[1])
    );

    // Highest set bit of a nonzero value: floor(log2(d)).
    function automatic logic [1:0] top_bit(input logic [3:0] dv);
        int r;
        r = $clog2(int'(dv) + 1) - 1;
        return r[1:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_v[k]   <= 1'b0;
                m_a[k]   <= 2'd0;
                m_mul[k] <= 1'b0;
                m_rel[k] <= 1'b0;
            end else if (m_v[k]) begin
                if (ack[k]) begin
                    m_v[k]   <= 1'b0;
                    m_rel[k] <= (k == 0);
                end
            end else if (m_rel[k]) begin
                if (d[k] == 4'd0) m_rel[k] <= 1'b0;
            end else if (e[k] && d[k] != 4'd0) begin
                m_v[k]   <= 1'b1;
                m_a[k]   <= top_bit(d[k]);
                m_mul[k] <= ($countones(d[k]) > 1);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (v_o[k] !== m_v[k] || a_o[k] !== m_a[k] || mul_o[k] !== m_mul[k]) begin
                errors++;
                $display("FAIL model[%0d] @%0t: got A=%0d V=%0b MULTI=%0b expected A=%0d V=%0b MULTI=%0b",
                         k, $time, a_o[k], v_o[k], mul_o[k], m_a[k], m_v[k], m_mul[k]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk0(input string name, input int ea, input int ev, input int em);
        chk({name, ".A"}, int'(a_o[0]), ea);
        chk({name, ".V"}, int'(v_o[0]), ev);
        chk({name, ".MULTI"}, int'(mul_o[0]), em);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e[k] = 1'b0; d[k] = 4'd0; ack[k] = 1'b0;
        end
        cyc(2);
        chk0("reset", 0, 0, 0);
        rst = 1'b0;

        // Capture 0100, then changing D without ack must not disturb the held code
        e[0] = 1'b1; d[0] = 4'b0100;
        cyc(1);
        chk0("cap0100", 2, 1, 0);
        d[0] = 4'b0001;
        cyc(2);
        chk0("hold_no_ack", 2, 1, 0);

        // Asynchronous reset in HOLD clears outputs without waiting for an edge
        #2 rst = 1'b1;
        #1 chk0("async_rst", 0, 0, 0);
        cyc(1);
        rst = 1'b0; e[0] = 1'b0; d[0] = 4'd0;
        cyc(1);
        chk0("post_rst_idle", 0, 0, 0);
        e[0] = 1'b1; d[0] = 4'b0001;
        cyc(1);
        chk0("cap_after_rst", 0, 1, 0);
        ack[0] = 1'b1;
        cyc(1);
        ack[0] = 1'b0; d[0] = 4'd0;
        cyc(1);

        // Multi-bit request, ack, blocked re-capture until D returns to zero
        d[0] = 4'b1011;
        cyc(1);
        chk0("cap1011", 3, 1, 1);
        ack[0] = 1'b1;
        cyc(1);
        ack[0] = 1'b0;
        chk0("ack_drop", 3, 0, 1);
        d[0] = 4'b0010;
        cyc(2);
        chk0("release_block", 3, 0, 1);
        d[0] = 4'd0;
        cyc(1);
        d[0] = 4'b0010;
        cyc(1);
        chk0("cap0010", 1, 1, 0);
        ack[0] = 1'b1; d[0] = 4'd0;
        cyc(1);
        ack[0] = 1'b0;
        cyc(1);

        // Disabled: no capture for any nonzero D
        e[0] = 1'b0;
        for (int v = 1; v < 16; v++) begin
            d[0] = v[3:0];
            cyc(1);
            chk("disabled_V", int'(v_o[0]), 0);
        end
        d[0] = 4'd0;
        cyc(1);
        e[0] = 1'b1; d[0] = 4'b1111;
        cyc(1);
        chk0("cap1111", 3, 1, 1);
        e[0] = 1'b0; d[0] = 4'd0;
        cyc(3);
        chk0("E_low_in_hold", 3, 1, 1);
        ack[0] = 1'b1;
        cyc(1);
        ack[0] = 1'b0;
        chk("ack_after_E_low", int'(v_o[0]), 0);
        cyc(1);

        // Loopback from a 2-to-4 decoder with E=1
        e[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d[0] = 4'b0001 << k;
            cyc(1);
            chk0("loopback", k, 1, 0);
            ack[0] = 1'b1; d[0] = 4'd0;
            cyc(1);
            ack[0] = 1'b0;
            cyc(1);
        end

        // Immediate re-arm: with ack held, V alternates while A stays 3
        e[1] = 1'b1; d[1] = 4'b1000; ack[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("rearm0.V", int'(v_o[1]), (i % 2 == 0) ? 1 : 0);
            chk("rearm0.A", int'(a_o[1]), 3);
        end
        ack[1] = 1'b0; e[1] = 1'b0; d[1] = 4'd0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
